btb_bpred: RTL and testbench

Parametrised branch target buffer plus pattern-history-table predictor feeding `pc_gen` in the 5-stage RV32I core. In Fetch it does a combinational lookup on `pcF` and produces `BTBHitF`, `BpredF` and `branchimmF`. In Decode it is trained by the resolved branch outcome. It replaces the fixed single-entry prediction path with configurable BTB/PHT depths and optional global-history (gshare) indexing.

---
 rtl/bpred_pkg.sv | 30 +++
 rtl/bpred_pht.sv | 54 +++++
 rtl/btb_bpred.sv | 100 ++++++++++
 tb/tb_btb_bpred.sv | 133 +++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types, constants and width helpers for the branch predictor.
package bpred_pkg;

  typedef logic [1:0] sat2_t;

  localparam sat2_t SAT2_SNT   = 2'b00;
  localparam sat2_t SAT2_WNT   = 2'b01;
  localparam sat2_t SAT2_WT    = 2'b10;
  localparam sat2_t SAT2_ST    = 2'b11;
  localparam sat2_t SAT2_RESET = SAT2_WNT;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic sat2_t sat2_next(sat2_t c, logic taken);
    sat2_t n;
    if (taken) n = (c == SAT2_ST)  ? c : c + 2'd1;
    else       n = (c == SAT2_SNT) ? c : c - 2'd1;
    return n;
  endfunction

  // Index width for a power-of-two table.
  function automatic int idx_bits(int entries);
    return $clog2(entries);
  endfunction

  // Tag width for a direct-mapped table indexed by word-aligned PC bits.
  function automatic int tag_bits(int entries);
    return 30 - $clog2(entries);
  endfunction

endpackage

// File: rtl/bpred_pht.sv
// Pattern history table of 2-bit counters with optional gshare indexing.
// Build option: define BPRED_GSHARE_EN to XOR the index with global history.
module bpred_pht
  import bpred_pkg::*;
#(
  parameter int PHT_ENTRIES = 64,
  parameter int GHR_BITS    = 6,
  localparam int IP         = idx_bits(PHT_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IP-1:0] pc_idx,
  output logic [IP-1:0] idx,
  output logic          ctr_msb,
  input  logic          upd_valid,
  input  logic          upd_taken,
  input  logic [IP-1:0] upd_pht_idx
);

  sat2_t pht [PHT_ENTRIES];

`ifdef BPRED_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;
  logic [IP-1:0]       ghr_ext;

  // Global history shifts in resolved outcomes, never speculative ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ghr <= '0;
    else if (upd_valid) ghr <= {ghr[GHR_BITS-2:0], upd_taken};
  end

  // Zero-extend history to the index width.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_BITS-1:0] = ghr;
  end

  assign idx = pc_idx ^ ghr_ext;
`else
  assign idx = pc_idx;
`endif

  assign ctr_msb = pht[idx][1];

  // Counter training at the index carried from fetch time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= SAT2_RESET;
    end else if (upd_valid) begin
      pht[upd_pht_idx] <= sat2_next(pht[upd_pht_idx], upd_taken);
    end
  end

endmodule

// File: rtl/btb_bpred.sv
// Direct-mapped branch target buffer plus PHT direction predictor.
// Build option: BPRED_GSHARE_EN selects gshare indexing in bpred_pht.
module btb_bpred
  import bpred_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_ENTRIES = 64,
  parameter int GHR_BITS    = 6,
  localparam int IP         = idx_bits(PHT_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pcF,
  output logic          BTBHitF,
  output logic          BpredF,
  output logic [31:0]   branchimmF,
  output logic [IP-1:0] pht_idxF,
  input  logic          upd_valid,
  input  logic [31:0]   upd_pc,
  input  logic [31:0]   upd_imm,
  input  logic          upd_taken,
  input  logic [IP-1:0] upd_pht_idx
);

  localparam int IB = idx_bits(BTB_ENTRIES);
  localparam int TB = tag_bits(BTB_ENTRIES);

  // Parameter sanity at elaboration.
  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)
    $error("BTB_ENTRIES must be a power of two and at least 2");
  if ((PHT_ENTRIES & (PHT_ENTRIES - 1)) != 0 || PHT_ENTRIES < BTB_ENTRIES)
    $error("PHT_ENTRIES must be a power of two and at least BTB_ENTRIES");
  if (GHR_BITS > IP)
    $error("GHR_BITS must not exceed log2(PHT_ENTRIES)");
`ifdef BPRED_GSHARE_EN
  if (GHR_BITS < 2)
    $error("GHR_BITS must be at least 2 for gshare");
`endif

  logic          btb_valid [BTB_ENTRIES];
  logic [TB-1:0] btb_tag   [BTB_ENTRIES];
  logic [31:0]   btb_imm   [BTB_ENTRIES];

  logic [IB-1:0] look_idx, upd_idx;
  logic [TB-1:0] look_tag, upd_tag;
  logic          upd_hit, btb_we;
  logic          pht_msb;
  logic          unused_pc_bits;

  assign look_idx = pcF[IB+1:2];
  assign look_tag = pcF[31:IB+2];
  assign upd_idx  = upd_pc[IB+1:2];
  assign upd_tag  = upd_pc[31:IB+2];
  assign unused_pc_bits = &{1'b0, pcF[1:0], upd_pc[1:0]};

  // Fetch-time lookup straight from the registered arrays; no write bypass.
  always_comb begin
    BTBHitF    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    BpredF     = pht_msb & BTBHitF;
    branchimmF = BTBHitF ? btb_imm[look_idx] : 32'h0;
  end

  // Write on a hit (refresh) or on a taken miss (allocate over the victim).
  always_comb begin
    upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    btb_we  = upd_valid && (upd_hit || upd_taken);
  end

  // Valid bits are the only BTB state cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid[upd_idx] <= 1'b1;
    end
  end

  // Tag and immediate payload; meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[upd_idx] <= upd_tag;
      btb_imm[upd_idx] <= upd_imm;
    end
  end

  bpred_pht #(
    .PHT_ENTRIES (PHT_ENTRIES),
    .GHR_BITS    (GHR_BITS)
  ) u_pht (
    .clk         (clk),
    .reset       (reset),
    .pc_idx      (pcF[IP+1:2]),
    .idx         (pht_idxF),
    .ctr_msb     (pht_msb),
    .upd_valid   (upd_valid),
    .upd_taken   (upd_taken),
    .upd_pht_idx (upd_pht_idx)
  );

endmodule

// File: tb/tb_btb_bpred.sv
// Directed bench for btb_bpred with hand-computed expectations.
module tb_btb_bpred;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pcF = 32'h0;
  logic        BTBHitF, BpredF;
  logic [31:0] branchimmF;
  logic [5:0]  pht_idxF;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic [31:0] upd_imm = 32'h0;
  logic        upd_taken = 1'b0;
  logic [5:0]  upd_pht_idx = 6'h0;

  int n_cmp = 0;
  int n_bad = 0;

  btb_bpred dut (
    .clk         (clk),
    .reset       (reset),
    .pcF         (pcF),
    .BTBHitF     (BTBHitF),
    .BpredF      (BpredF),
    .branchimmF  (branchimmF),
    .pht_idxF    (pht_idxF),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_imm     (upd_imm),
    .upd_taken   (upd_taken),
    .upd_pht_idx (upd_pht_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive pcF away from the clock edge and check all lookup outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic pred, input logic [31:0] imm, input logic [5:0] idx);
    pcF = pc;
    #1;
    chk({tag, ".hit"},  {31'h0, BTBHitF}, {31'h0, hit});
    chk({tag, ".pred"}, {31'h0, BpredF},  {31'h0, pred});
    chk({tag, ".imm"},  branchimmF, imm);
    chk({tag, ".idx"},  {26'h0, pht_idxF}, {26'h0, idx});
  endtask

  // One update pulse spanning exactly one rising edge.
  task automatic upd(input logic [31:0] pc, input logic [31:0] imm,
                     input logic taken, input logic [5:0] idx);
    @(negedge clk);
    upd_pc = pc; upd_imm = imm; upd_taken = taken; upd_pht_idx = idx;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    #2;
    look("rst_hold", 32'h100, 1'b0, 1'b0, 32'h0, 6'h00);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

`ifdef BPRED_GSHARE_EN
    look("g_cold", 32'h100, 1'b0, 1'b0, 32'h0, 6'h00);
    upd(32'h104, 32'h8, 1'b1, 6'h01);
    upd(32'h104, 32'h8, 1'b1, 6'h01);
    upd(32'h104, 32'h8, 1'b0, 6'h01);
    look("g_ttn_100", 32'h100, 1'b0, 1'b0, 32'h0, 6'h06);
    #1 look("g_ttn_104", 32'h104, 1'b1, 1'b0, 32'h8, 6'h07);
`else
    look("cold", 32'h100, 1'b0, 1'b0, 32'h0, 6'h00);
    upd(32'h100, 32'h40, 1'b1, 6'h00);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h40, 6'h00);

    // Same-cycle lookup and not-taken update: old state then new state.
    @(negedge clk);
    upd_pc = 32'h100; upd_imm = 32'h40; upd_taken = 1'b0; upd_pht_idx = 6'h00;
    upd_valid = 1'b1;
    look("same_pre", 32'h100, 1'b1, 1'b1, 32'h40, 6'h00);
    @(negedge clk);
    upd_valid = 1'b0;
    look("same_post", 32'h100, 1'b1, 1'b0, 32'h40, 6'h00);

    upd(32'h100, 32'h40, 1'b0, 6'h00);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h40, 6'h00);
    upd(32'h100, 32'h40, 1'b0, 6'h00);
    upd(32'h100, 32'h40, 1'b0, 6'h00);
    look("nt_sat", 32'h100, 1'b1, 1'b0, 32'h40, 6'h00);
    upd(32'h100, 32'h40, 1'b1, 6'h00);
    look("t_from00", 32'h100, 1'b1, 1'b0, 32'h40, 6'h00);
    upd(32'h100, 32'h40, 1'b1, 6'h00);
    look("t_to10", 32'h100, 1'b1, 1'b1, 32'h40, 6'h00);

    upd(32'h204, 32'h10, 1'b0, 6'h01);
    look("nt_miss", 32'h204, 1'b0, 1'b0, 32'h0, 6'h01);

    upd(32'h140, 32'h80, 1'b1, 6'h10);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h0, 6'h00);
    #1 look("alias_new", 32'h140, 1'b1, 1'b1, 32'h80, 6'h10);

    @(negedge clk);
    upd_pc = 32'h300; upd_imm = 32'h99; upd_taken = 1'b1; upd_pht_idx = 6'h00;
    @(negedge clk);
    look("no_valid", 32'h300, 1'b0, 1'b0, 32'h0, 6'h00);

    // Mid-operation reset: everything restarts cold.
    @(negedge clk); reset = 1'b0;
    look("mid_rst", 32'h140, 1'b0, 1'b0, 32'h0, 6'h10);
    @(negedge clk); reset = 1'b1;
    upd(32'h140, 32'h80, 1'b0, 6'h10);
    upd(32'h140, 32'h84, 1'b1, 6'h10);
    look("post_rst", 32'h140, 1'b1, 1'b0, 32'h84, 6'h10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
